periph_timer: RTL and testbench



---
 rtl/periph_timer.sv | 165 ++++++++++++++++
 tb/tb_periph_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_timer.sv
// rtl/periph_timer.sv - 16-bit memory-mapped timer with prescaler, up/continuous/up-down modes and IRQ
module periph_timer #(
    parameter logic [15:0] ADDR_CTL  = 16'h0160,
    parameter logic [15:0] ADDR_TR   = 16'h0170,
    parameter logic [15:0] ADDR_CCR0 = 16'h0172
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MAB_in,
    input  logic [15:0] MDB_in,
    input  logic        MW,
    input  logic        BW,
    output logic        PER_sel,
    output logic [15:0] PER_out,
    output logic        IRQ
);
    logic [1:0]  r_id;
    logic [1:0]  r_mc;
    logic        r_tie;
    logic        r_tifg;
    logic        r_dir_down;
    logic [15:0] r_tr;
    logic [15:0] r_ccr0;
    logic [2:0]  r_pre;

    logic        w_hit_ctl, w_hit_tr, w_hit_ccr0;
    logic        w_wr_ctl, w_wr_tr, w_wr_ccr0;
    logic [15:0] w_ctl_rd, w_rd_word;
    logic [15:0] w_ctl_wdata, w_tr_wdata, w_ccr0_wdata;
    logic [2:0]  w_pre_last, w_pre_next;
    logic        w_tick;
    logic [15:0] w_tr_next;
    logic        w_dir_next;
    logic        w_tifg_hw;

    function automatic logic [15:0] f_merge(input logic [15:0] old_v, input logic [15:0] data,
                                            input logic byte_wr, input logic odd);
        if (!byte_wr)
            return data;
        if (odd)
            return {data[7:0], old_v[7:0]};
        return {old_v[15:8], data[7:0]};
    endfunction

    assign w_hit_ctl  = (MAB_in[15:1] == ADDR_CTL[15:1]);
    assign w_hit_tr   = (MAB_in[15:1] == ADDR_TR[15:1]);
    assign w_hit_ccr0 = (MAB_in[15:1] == ADDR_CCR0[15:1]);
    assign w_wr_ctl   = MW & w_hit_ctl;
    assign w_wr_tr    = MW & w_hit_tr;
    assign w_wr_ccr0  = MW & w_hit_ccr0;

    // TCLR is an action bit: it is never stored, so it always reads back 0
    assign w_ctl_rd     = {6'b0, r_id, 2'b0, r_mc, 2'b0, r_tie, r_tifg};
    assign w_ctl_wdata  = f_merge(w_ctl_rd, MDB_in, BW, MAB_in[0]);
    assign w_tr_wdata   = f_merge(r_tr, MDB_in, BW, MAB_in[0]);
    assign w_ccr0_wdata = f_merge(r_ccr0, MDB_in, BW, MAB_in[0]);

    always_comb begin
        w_rd_word = 16'h0000;
        if (w_hit_ctl)
            w_rd_word = w_ctl_rd;
        else if (w_hit_tr)
            w_rd_word = r_tr;
        else if (w_hit_ccr0)
            w_rd_word = r_ccr0;
    end

    assign PER_sel = w_hit_ctl | w_hit_tr | w_hit_ccr0;
    assign PER_out = !PER_sel ? 16'h0000 :
                     BW       ? {8'h00, (MAB_in[0] ? w_rd_word[15:8] : w_rd_word[7:0])} :
                                w_rd_word;
    assign IRQ     = r_tie & r_tifg;

    always_comb begin
        case (r_id)
            2'd0:    w_pre_last = 3'd0;
            2'd1:    w_pre_last = 3'd1;
            2'd2:    w_pre_last = 3'd3;
            default: w_pre_last = 3'd7;
        endcase
    end

    assign w_tick     = (r_mc != 2'b00) && (r_pre == w_pre_last);
    assign w_pre_next = (r_mc == 2'b00) ? r_pre : (w_tick ? 3'd0 : r_pre + 3'd1);

    always_comb begin
        w_tr_next  = r_tr;
        w_dir_next = r_dir_down;
        w_tifg_hw  = 1'b0;
        if (w_tick) begin
            case (r_mc)
                2'b01: begin
                    if (r_tr >= r_ccr0) begin
                        w_tr_next = 16'h0000;
                        w_tifg_hw = 1'b1;
                    end else begin
                        w_tr_next = r_tr + 16'd1;
                    end
                end
                2'b10: begin
                    w_tr_next = r_tr + 16'd1;
                    w_tifg_hw = (r_tr == 16'hFFFF);
                end
                2'b11: begin
                    // A zero period parks the counter at 0 without flagging
                    if (r_ccr0 == 16'h0000) begin
                        w_tr_next  = 16'h0000;
                        w_dir_next = 1'b0;
                    end else if (!r_dir_down) begin
                        if (r_tr >= r_ccr0) begin
                            w_dir_next = 1'b1;
                            w_tr_next  = r_ccr0 - 16'd1;
                        end else begin
                            w_tr_next = r_tr + 16'd1;
                        end
                    end else if (r_tr == 16'd1) begin
                        w_tr_next  = 16'h0000;
                        w_tifg_hw  = 1'b1;
                        w_dir_next = 1'b0;
                    end else if (r_tr == 16'd0) begin
                        w_tr_next  = 16'd1;
                        w_dir_next = 1'b0;
                    end else begin
                        w_tr_next = r_tr - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id       <= 2'b00;
            r_mc       <= 2'b00;
            r_tie      <= 1'b0;
            r_tifg     <= 1'b0;
            r_dir_down <= 1'b0;
            r_tr       <= 16'h0000;
            r_ccr0     <= 16'h0000;
            r_pre      <= 3'd0;
        end else begin
            r_pre      <= w_pre_next;
            r_tr       <= w_tr_next;
            r_dir_down <= w_dir_next;
            r_tifg     <= r_tifg | w_tifg_hw;
            if (w_wr_ctl) begin
                r_id   <= w_ctl_wdata[9:8];
                r_mc   <= w_ctl_wdata[5:4];
                r_tie  <= w_ctl_wdata[1];
                r_tifg <= w_ctl_wdata[0] | w_tifg_hw;
                if (w_ctl_wdata[2]) begin
                    r_tr       <= 16'h0000;
                    r_pre      <= 3'd0;
                    r_dir_down <= 1'b0;
                end
            end
            // Bus write to TR wins over the counting update computed above
            if (w_wr_tr)
                r_tr <= w_tr_wdata;
            if (w_wr_ccr0)
                r_ccr0 <= w_ccr0_wdata;
        end
    end
endmodule

// File: tb/tb_periph_timer.sv
// tb/tb_periph_timer.sv - randomized scoreboard bench for periph_timer against a behavioural model
module tb_periph_timer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] MAB_in;
    logic [15:0] MDB_in;
    logic        MW;
    logic        BW;
    logic        PER_sel;
    logic [15:0] PER_out;
    logic        IRQ;

    periph_timer dut (
        .clk(clk), .rst(rst), .MAB_in(MAB_in), .MDB_in(MDB_in), .MW(MW), .BW(BW),
        .PER_sel(PER_sel), .PER_out(PER_out), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [15:0] out;
        logic        irq;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    int          m_id, m_mc, m_pre;
    logic        m_tie, m_tifg, m_down;
    logic [15:0] m_tr, m_ccr0;

    function automatic int reg_of(input logic [15:0] a);
        int wa;
        wa = int'(a) / 2;
        if (wa == 16'h0160 / 2) return 1;
        if (wa == 16'h0170 / 2) return 2;
        if (wa == 16'h0172 / 2) return 3;
        return 0;
    endfunction

    function automatic logic [15:0] ctl_value();
        return 16'(m_id * 256 + m_mc * 16 + int'(m_tie) * 2 + int'(m_tifg));
    endfunction

    function automatic logic [15:0] byte_merge(input logic [15:0] old_v, input logic [15:0] a,
                                               input logic bw, input logic [15:0] d);
        int lo, hi;
        if (!bw) return d;
        lo = int'(old_v) % 256;
        hi = int'(old_v) / 256;
        if (a % 2 == 1) hi = int'(d) % 256;
        else            lo = int'(d) % 256;
        return 16'(hi * 256 + lo);
    endfunction

    function automatic exp_t model_read(input logic [15:0] a, input logic bw);
        exp_t e;
        int   r, v;
        r = reg_of(a);
        v = (r == 1) ? int'(ctl_value()) : (r == 2) ? int'(m_tr) : (r == 3) ? int'(m_ccr0) : 0;
        if (bw) v = (a % 2 == 1) ? v / 256 : v % 256;
        e.sel  = (r != 0);
        e.out  = 16'(v);
        e.irq  = m_tie & m_tifg;
        e.name = "";
        return e;
    endfunction

    task automatic model_reset();
        m_id = 0; m_mc = 0; m_pre = 0;
        m_tie = 0; m_tifg = 0; m_down = 0;
        m_tr = 0; m_ccr0 = 0;
    endtask

    task automatic model_step(input logic mw, input logic bw, input logic [15:0] a, input logic [15:0] d);
        int          period, r;
        logic        tick, event_flag, nd;
        logic [15:0] nt, w;
        int          np;
        period = 1 << m_id;
        tick = 0; event_flag = 0;
        np = m_pre; nt = m_tr; nd = m_down;
        if (m_mc != 0) begin
            tick = (m_pre == period - 1);
            np   = tick ? 0 : (m_pre + 1) % 8;
        end
        if (tick) begin
            if (m_mc == 1) begin
                if (m_tr >= m_ccr0) begin nt = 0; event_flag = 1; end
                else nt = m_tr + 1;
            end else if (m_mc == 2) begin
                nt = m_tr + 1;
                event_flag = (m_tr == 16'hFFFF);
            end else if (m_ccr0 == 0) begin
                nt = 0; nd = 0;
            end else if (!m_down) begin
                if (m_tr >= m_ccr0) begin nd = 1; nt = m_ccr0 - 1; end
                else nt = m_tr + 1;
            end else begin
                case (m_tr)
                    16'd1:   begin nt = 0; event_flag = 1; nd = 0; end
                    16'd0:   begin nt = 1; nd = 0; end
                    default: nt = m_tr - 1;
                endcase
            end
        end
        r = mw ? reg_of(a) : 0;
        m_tifg = m_tifg | event_flag;
        if (r == 1) begin
            w = byte_merge(ctl_value(), a, bw, d);
            m_id   = int'(w[9:8]);
            m_mc   = int'(w[5:4]);
            m_tie  = w[1];
            m_tifg = w[0] | event_flag;
            if (w[2]) begin nt = 0; np = 0; nd = 0; end
        end
        if (r == 2) nt = byte_merge(m_tr, a, bw, d);
        if (r == 3) m_ccr0 = byte_merge(m_ccr0, a, bw, d);
        m_tr = nt; m_pre = np; m_down = nd;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: DUT output present with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                n_pass++;
                n_checks += 2;
                if (PER_sel !== e.sel) begin
                    n_pass--;
                    $display("FAIL %s PER_sel: got %b expected %b", e.name, PER_sel, e.sel);
                end
                if (PER_out === e.out) n_pass++;
                else $display("FAIL %s PER_out: got %h expected %h (addr %h bw %b)", e.name, PER_out, e.out, MAB_in, BW);
                if (IRQ === e.irq) n_pass++;
                else $display("FAIL %s IRQ: got %b expected %b", e.name, IRQ, e.irq);
            end
        end
    end

    task automatic drive(input logic mw, input logic bw, input logic [15:0] a, input logic [15:0] d, input exp_t e);
        MW = mw; BW = bw; MAB_in = a; MDB_in = d;
        exp_q.push_back(e);
        chk_en = 1'b1;
        @(posedge clk);
        model_step(mw, bw, a, d);
        #1;
    endtask

    task automatic cyc(input logic mw, input logic bw, input logic [15:0] a, input logic [15:0] d, input string nm);
        exp_t e;
        e = model_read(a, bw);
        e.name = nm;
        drive(mw, bw, a, d, e);
    endtask

    task automatic rd_exp(input logic bw, input logic [15:0] a, input logic sel, input logic [15:0] v,
                          input logic irq, input string nm);
        exp_t e;
        e.sel = sel; e.out = v; e.irq = irq; e.name = nm;
        drive(1'b0, bw, a, 16'h0000, e);
    endtask

    task automatic do_reset(input int cycles);
        chk_en = 1'b0;
        rst = 1'b1;
        MW = 1'b1; BW = 1'b0; MAB_in = 16'h0170; MDB_in = 16'h5A5A;
        for (int i = 0; i < cycles; i++) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0; MW = 1'b0;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 16'h0160;
            1: return 16'h0161;
            2: return 16'h0170;
            3: return 16'h0171;
            4: return 16'h0172;
            5: return 16'h0173;
            6: return 16'h0200;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] d;
        int          sel_r;
        logic        bw;
        rst = 1'b1; MW = 1'b0; BW = 1'b0; MAB_in = 16'h0; MDB_in = 16'h0;
        model_reset();
        @(posedge clk); #1;

        // reset values and decode
        do_reset(2);
        rd_exp(0, 16'h0160, 1, 16'h0000, 0, "rst_tctl");
        rd_exp(0, 16'h0170, 1, 16'h0000, 0, "rst_tr");
        rd_exp(0, 16'h0172, 1, 16'h0000, 0, "rst_ccr0");
        rd_exp(0, 16'h0200, 0, 16'h0000, 0, "unmapped_rd");

        // up mode, divide by 1
        do_reset(2);
        cyc(1, 0, 16'h0172, 16'h0003, "up_wr_ccr0");
        cyc(1, 0, 16'h0160, 16'h0012, "up_wr_tctl");
        rd_exp(0, 16'h0170, 1, 16'h0000, 0, "up_tr0");
        rd_exp(0, 16'h0170, 1, 16'h0001, 0, "up_tr1");
        rd_exp(0, 16'h0170, 1, 16'h0002, 0, "up_tr2");
        rd_exp(0, 16'h0170, 1, 16'h0003, 0, "up_tr3");
        rd_exp(0, 16'h0170, 1, 16'h0000, 1, "up_wrap_irq");
        cyc(1, 0, 16'h0160, 16'h0010, "up_clr_tifg");
        rd_exp(0, 16'h0170, 1, 16'h0002, 0, "up_irq_low");

        // prescaler /8 and TCLR restart
        do_reset(2);
        cyc(1, 0, 16'h0172, 16'hFFFF, "pre_ccr0");
        cyc(1, 0, 16'h0160, 16'h0320, "pre_tctl");
        for (int i = 0; i < 20; i++) cyc(0, 0, 16'h0170, 16'h0, "pre_count");
        cyc(1, 0, 16'h0160, 16'h0324, "pre_tclr");
        rd_exp(0, 16'h0170, 1, 16'h0000, 0, "pre_tclr_tr0");
        for (int i = 0; i < 12; i++) cyc(0, 0, 16'h0170, 16'h0, "pre_restart");

        // continuous wrap; software clear on the wrap edge must lose to the event
        do_reset(2);
        cyc(1, 0, 16'h0170, 16'hFFFE, "cont_wr_tr");
        cyc(1, 0, 16'h0160, 16'h0020, "cont_tctl");
        rd_exp(0, 16'h0170, 1, 16'hFFFE, 0, "cont_fffe");
        cyc(1, 0, 16'h0160, 16'h0020, "cont_wrap_wr");
        rd_exp(0, 16'h0160, 1, 16'h0021, 0, "cont_tifg_kept");
        cyc(0, 0, 16'h0170, 16'h0, "cont_after");

        // up/down with period 2
        do_reset(2);
        cyc(1, 0, 16'h0172, 16'h0002, "ud_ccr0");
        cyc(1, 0, 16'h0160, 16'h0030, "ud_tctl");
        begin
            logic [15:0] ud_seq [9];
            ud_seq = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
            for (int i = 0; i < 9; i++) rd_exp(0, 16'h0170, 1, ud_seq[i], 0, "ud_seq");
        end
        rd_exp(0, 16'h0160, 1, 16'h0031, 0, "ud_tifg");

        // byte access and bus write beating a tick
        do_reset(2);
        cyc(1, 1, 16'h0173, 16'hABAB, "byte_wr_hi");
        rd_exp(0, 16'h0172, 1, 16'hAB00, 0, "byte_ccr0_word");
        rd_exp(1, 16'h0173, 1, 16'h00AB, 0, "byte_rd_hi");
        rd_exp(1, 16'h0172, 1, 16'h0000, 0, "byte_rd_lo");
        cyc(1, 0, 16'h0160, 16'h0020, "byte_cont");
        cyc(1, 0, 16'h0170, 16'h1234, "tick_vs_wr");
        rd_exp(0, 16'h0170, 1, 16'h1234, 0, "tr_wr_wins");
        cyc(1, 0, 16'h0200, 16'hFFFF, "nohit_wr");
        cyc(0, 0, 16'h0160, 16'h0, "nohit_tctl");
        cyc(0, 0, 16'h0172, 16'h0, "nohit_ccr0");

        // randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 2500; i++) begin
            sel_r = $urandom_range(0, 99);
            bw = ($urandom_range(0, 7) == 0);
            if (sel_r < 45) begin
                cyc(0, bw, pick_addr(), 16'($urandom), "rand_rd");
            end else if (sel_r < 55) begin
                d = 16'($urandom);
                if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
                if ($urandom_range(0, 1) != 0) d[9:8] = 2'($urandom_range(0, 1));
                cyc(1, bw, 16'h0160 | 16'($urandom_range(0, 1)), d, "rand_tctl");
            end else if (sel_r < 65) begin
                d = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
                cyc(1, bw, 16'h0172 | 16'($urandom_range(0, 1)), d, "rand_ccr0");
            end else if (sel_r < 72) begin
                d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'hFFF0 | 16'($urandom_range(0, 15));
                cyc(1, bw, 16'h0170 | 16'($urandom_range(0, 1)), d, "rand_tr");
            end else if (sel_r < 78) begin
                cyc(1, bw, pick_addr(), 16'($urandom), "rand_wr");
            end else if (sel_r < 79) begin
                do_reset(1);
                rd_exp(0, 16'h0170, 1, 16'h0000, 0, "midrun_rst");
            end else begin
                cyc(0, 0, 16'h0170, 16'h0, "rand_tr_rd");
            end
        end

        chk_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_leftover: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
